// File: rtl/pixel_fifo_writer.sv
// Packs captured RGB888 pixels to RGB565, buffers {addr, pixel} in a small FIFO
// and drains it to the frame-buffer port; tracks drops and end-of-frame.
module pixel_fifo_writer #(
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [23:0]       data_out,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              full,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic              frame_done,
  input  logic              clear_status
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 16;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        rgb565;
  logic               push;
  logic               pop;
  logic               drop;
  logic               last_pixel_pop;

  always_comb begin
    rgb565         = {data_out[23:19], data_out[15:10], data_out[7:3]};
    full           = (count == CNT_W'(DEPTH));
    mem_valid      = (count != '0);
    push           = write_en && !full;
    drop           = write_en && full;
    pop            = mem_valid && mem_ready;
    mem_addr       = fifo_mem[rd_ptr][ENTRY_W-1:16];
    mem_wdata      = fifo_mem[rd_ptr][15:0];
    last_pixel_pop = pop && (mem_addr == ADDR_W'(FRAME_PIXELS - 1));
  end

  // Storage needs no reset: entries are only observed while mem_valid=1.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {addr, rgb565};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      frame_done <= last_pixel_pop;
    end
  end

  // A clear in the same cycle as a drop wins; the drop is not counted.
  always_ff @(posedge clk) begin
    if (reset || clear_status) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Directed bench for pixel_fifo_writer: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_pixel_fifo_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [18:0] addr;
  logic [23:0] data_out;
  logic        mem_valid;
  logic        mem_ready;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        full;
  logic        overflow;
  logic [15:0] drop_count;
  logic        frame_done;
  logic        clear_status;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pixel_fifo_writer #(.DEPTH(16), .FRAME_PIXELS(307200), .ADDR_W(19)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .addr(addr),
    .data_out(data_out), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full),
    .overflow(overflow), .drop_count(drop_count), .frame_done(frame_done),
    .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel pattern for index i: R=i*8, G=i*4, B=i*8 -> RGB565 {i[4:0], i[5:0], i[4:0]}
  function automatic logic [23:0] pix(input int unsigned i);
    logic [7:0] r, g;
    r = 8'(i << 3);
    g = 8'(i << 2);
    return {r, g, r};
  endfunction

  function automatic logic [15:0] pix565(input int unsigned i);
    logic [5:0] v;
    v = 6'(i);
    return {v[4:0], v, v[4:0]};
  endfunction

  initial begin
    reset = 1'b1; write_en = 1'b0; addr = '0; data_out = '0;
    mem_ready = 1'b0; clear_status = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);

    // Single pixel round trip
    write_en = 1'b1; addr = 19'd5; data_out = 24'hFF8040; mem_ready = 1'b1;
    tick();
    write_en = 1'b0;
    chk("one_valid", 32'(mem_valid), 32'd1);
    chk("one_addr", 32'(mem_addr), 32'd5);
    chk("one_wdata", 32'(mem_wdata), 32'hFC08);
    tick();
    chk("one_empty", 32'(mem_valid), 32'd0);

    // Fill to full, overflow by 3, drain in order
    mem_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      write_en = 1'b1; addr = 19'(i); data_out = pix(i);
      tick();
      if (i == 14) chk("fill_not_full", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    data_out = 24'hFFFFFF;
    tick(); tick(); tick();
    write_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd3);
    chk("ovf_head", 32'(mem_addr), 32'd0);
    mem_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(mem_valid), 32'd1);
      chk("drain_addr", 32'(mem_addr), i);
      chk("drain_wdata", 32'(mem_wdata), 32'(pix565(i)));
      tick();
      if (i == 0) chk("drain_full_clr", 32'(full), 32'd0);
    end
    chk("drain_empty", 32'(mem_valid), 32'd0);

    // Streaming: push and pop every cycle, occupancy stays at 1
    write_en = 1'b1; addr = 19'd100; data_out = pix(0);
    tick();
    for (int unsigned i = 1; i < 100; i++) begin
      addr = 19'(100 + i); data_out = pix(i);
      chk("strm_addr", 32'(mem_addr), 100 + i - 1);
      chk("strm_wdata", 32'(mem_wdata), 32'(pix565(i - 1)));
      chk("strm_full", 32'(full), 32'd0);
      tick();
    end
    write_en = 1'b0;
    chk("strm_last", 32'(mem_addr), 32'd199);
    tick();
    chk("strm_empty", 32'(mem_valid), 32'd0);
    chk("strm_drops", 32'(drop_count), 32'd3);

    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Last pixel of frame stalled, then accepted
    mem_ready = 1'b0; write_en = 1'b1; addr = 19'd307199; data_out = 24'h0;
    tick();
    write_en = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("fd_stall", 32'(frame_done), 32'd0);
      chk("fd_head", 32'(mem_addr), 32'd307199);
      tick();
    end
    mem_ready = 1'b1;
    chk("fd_pre", 32'(frame_done), 32'd0);
    tick();
    chk("fd_pulse", 32'(frame_done), 32'd1);
    tick();
    chk("fd_after", 32'(frame_done), 32'd0);

    // Saturate drop_count
    mem_ready = 1'b0; write_en = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      addr = 19'(i); data_out = pix(i);
      tick();
    end
    repeat (65535) tick();
    chk("sat_ffff", 32'(drop_count), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    chk("sat_ovf", 32'(overflow), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("sat_clr", 32'(drop_count), 32'd0);
    chk("sat_clr_ovf", 32'(overflow), 32'd0);
    chk("sat_still_full", 32'(full), 32'd1);

    // Full with simultaneous pop: pixel still dropped
    mem_ready = 1'b1; addr = 19'd77;
    tick();
    write_en = 1'b0; mem_ready = 1'b0;
    chk("fullpop_drops", 32'(drop_count), 32'd1);
    chk("fullpop_full", 32'(full), 32'd0);
    chk("fullpop_head", 32'(mem_addr), 32'd1);

    // Mid-stream reset discards contents
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_en = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      addr = 19'(200 + i); data_out = pix(i);
      tick();
    end
    write_en = 1'b0;
    chk("pre_rst_head", 32'(mem_addr), 32'd200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    write_en = 1'b1; addr = 19'd42; data_out = 24'h123456;
    tick();
    write_en = 1'b0;
    chk("post_rst_valid", 32'(mem_valid), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'd42);
    chk("post_rst_wdata", 32'(mem_wdata), 32'h11AA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
